// File: rtl/mem_copy_pkg.sv
// rtl/mem_copy_pkg.sv - shared state encoding and default sizes for the block copier
package mem_copy_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } copy_state_e;

    localparam int DEFAULT_DEPTH = 100;
    localparam int DEFAULT_LEN_W = 8;

endpackage

// File: rtl/copy_addr_gen.sv
// rtl/copy_addr_gen.sv - source/destination pointers, remaining count and copy direction
module copy_addr_gen
    import mem_copy_pkg::*;
#(
    parameter int LEN_W = DEFAULT_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [31:0]      src_i,
    input  logic [31:0]      dst_i,
    input  logic [LEN_W-1:0] len_i,
    output logic [31:0]      src_ptr_o,
    output logic [31:0]      dst_ptr_o,
    output logic             last_o
);

    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             desc_q, desc_d;

    logic [32:0] src_end;
    logic [31:0] len_ext;
    logic        desc_now;

    // A destination that starts inside the source window would overwrite
    // unread source words on an ascending walk, so such copies run top-down.
    assign len_ext  = 32'(len_i);
    assign src_end  = {1'b0, src_i} + 33'(len_i);
    assign desc_now = (dst_i > src_i) && ({1'b0, dst_i} < src_end);

    // Load start pointers on accept; step once per written word.
    always_comb begin
        src_d  = src_q;
        dst_d  = dst_q;
        cnt_d  = cnt_q;
        desc_d = desc_q;
        if (load_i) begin
            desc_d = desc_now;
            cnt_d  = len_i;
            src_d  = desc_now ? (src_i + len_ext - 32'd1) : src_i;
            dst_d  = desc_now ? (dst_i + len_ext - 32'd1) : dst_i;
        end else if (step_i) begin
            cnt_d = cnt_q - LEN_W'(1);
            src_d = desc_q ? (src_q - 32'd1) : (src_q + 32'd1);
            dst_d = desc_q ? (dst_q - 32'd1) : (dst_q + 32'd1);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q  <= '0;
            dst_q  <= '0;
            cnt_q  <= '0;
            desc_q <= 1'b0;
        end else begin
            src_q  <= src_d;
            dst_q  <= dst_d;
            cnt_q  <= cnt_d;
            desc_q <= desc_d;
        end
    end

    assign src_ptr_o = src_q;
    assign dst_ptr_o = dst_q;
    assign last_o    = (cnt_q == LEN_W'(1));

endmodule

// File: rtl/mem_block_copier.sv
// rtl/mem_block_copier.sv - memmove-style word copy engine on the data-memory port (optional COPY_CHECKSUM_EN)
module mem_block_copier
    import mem_copy_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int LEN_W = DEFAULT_LEN_W
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      src,
    input  logic [31:0]      dst,
    input  logic [LEN_W-1:0] len,
    input  logic [31:0]      RD,
    output logic [31:0]      A,
    output logic [31:0]      WD,
    output logic             WE,
    output logic             mem_req,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      checksum
);

    copy_state_e state_q, state_d;
    logic        err_q, err_d;
    logic [31:0] data_q, data_d;

    logic        load, step, last;
    logic [31:0] src_ptr, dst_ptr;
    logic [32:0] src_sum, dst_sum;
    logic        oob;

    // 33-bit sums so an address near 2^32 cannot wrap past the bound.
    assign src_sum = {1'b0, src} + 33'(len);
    assign dst_sum = {1'b0, dst} + 33'(len);
    assign oob     = (src_sum > 33'(DEPTH)) || (dst_sum > 33'(DEPTH));

    copy_addr_gen #(.LEN_W(LEN_W)) u_addr_gen (
        .clk       (CLK),
        .rst       (rst),
        .load_i    (load),
        .step_i    (step),
        .src_i     (src),
        .dst_i     (dst),
        .len_i     (len),
        .src_ptr_o (src_ptr),
        .dst_ptr_o (dst_ptr),
        .last_o    (last)
    );

    // Next state and port drive; outputs depend on state only, so reset clears them at once.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        load    = 1'b0;
        step    = 1'b0;
        A       = 32'd0;
        WD      = 32'd0;
        WE      = 1'b0;
        busy    = 1'b0;
        mem_req = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (oob) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else if (len == '0) begin
                        state_d = S_DONE;
                        err_d   = 1'b0;
                    end else begin
                        state_d = S_RD;
                        err_d   = 1'b0;
                        load    = 1'b1;
                    end
                end
            end
            S_RD: begin
                A       = src_ptr;
                busy    = 1'b1;
                mem_req = 1'b1;
                state_d = S_WR;
            end
            S_WR: begin
                A       = dst_ptr;
                WD      = data_q;
                WE      = 1'b1;
                busy    = 1'b1;
                mem_req = 1'b1;
                step    = 1'b1;
                state_d = last ? S_DONE : S_RD;
            end
            S_DONE: begin
                done    = 1'b1;
                err     = err_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Capture the word being read so it can be written on the following cycle.
    always_comb begin
        data_d = data_q;
        if (state_q == S_RD) begin
            data_d = RD;
        end
    end

    // State, error flag and data register.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
            data_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

`ifdef COPY_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;
    logic        clr_sum;

    // Any request seen in IDLE restarts the sum, including rejected and empty ones.
    assign clr_sum = (state_q == S_IDLE) && start;

    // Accumulate each latched read word, wrapping mod 2^32.
    always_comb begin
        sum_d = sum_q;
        if (clr_sum) begin
            sum_d = 32'd0;
        end else if (state_q == S_RD) begin
            sum_d = sum_q + RD;
        end
    end

    // Checksum register.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            sum_q <= 32'd0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = 32'd0;
`endif

endmodule
